// File: rtl/dpram_fifo_pkg.sv
// Shared sizing for the dual-port-RAM FIFO controller and its output buffer.
package dpram_fifo_pkg;
    localparam int DW         = 8;
    localparam int AW         = 4;
    localparam int DEPTH      = 2 ** AW;
    localparam int OBUF_DEPTH = 2;

    typedef logic [DW-1:0] data_t;
    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   cnt_t;
endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Producer/consumer valid-ready streams around the FIFO controller.
interface dpram_fifo_ctrl_if;
    import dpram_fifo_pkg::*;

    logic  in_valid;
    logic  in_ready;
    data_t in_data;
    logic  out_valid;
    logic  out_ready;
    data_t out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dpram_fifo_ctrl_obuf2.sv
// Two-entry output buffer that soaks up the RAM read latency; slot0 is always the head.
module fifo_obuf2
    import dpram_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       pop,
    input  data_t      load_data,
    output data_t      head_data,
    output logic [1:0] obuf_cnt
);

    data_t      slot0_q, slot0_d;
    data_t      slot1_q, slot1_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q;
        case ({load, pop})
            2'b10: begin
                if (cnt_q == 2'd0) slot0_d = load_data;
                else               slot1_d = load_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b11: begin
                // Full buffer: head leaves, tail moves up and the new word takes the tail.
                if (cnt_q == 2'(OBUF_DEPTH)) begin
                    slot0_d = slot1_q;
                    slot1_d = load_data;
                end else begin
                    slot0_d = load_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign head_data = slot0_q;
    assign obuf_cnt  = cnt_q;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller for a 16x8 dual-port RAM: port 0 writes, port 1 reads, with a
// two-entry output buffer covering the one-cycle read latency.
module dpram_fifo_ctrl
    import dpram_fifo_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    dpram_fifo_ctrl_if.slave        s,
    output cnt_t                    count,
    output logic                    full,
    output logic                    empty,
    output logic                    ram_we_0,
    output logic                    ram_re_0,
    output addr_t                   ram_addr_0,
    output data_t                   ram_wdata_0,
    output logic                    ram_we_1,
    output logic                    ram_re_1,
    output addr_t                   ram_addr_1,
    input  data_t                   ram_rdata_1
);

    addr_t      wr_ptr_q, wr_ptr_d;
    addr_t      rd_ptr_q, rd_ptr_d;
    cnt_t       ram_occ_q, ram_occ_d;
    logic       pend_q, pend_d;
    logic       push, pop, rd_issue;
    logic [1:0] obuf_cnt;
    logic [2:0] obuf_claim;
    data_t      head_data;

    assign s.in_ready = (ram_occ_q != cnt_t'(DEPTH));

    always_comb begin
        push       = s.in_valid && s.in_ready;
        pop        = s.out_valid && s.out_ready;
        // Slots already owed to the buffer after this cycle's pop; keep it at most 2.
        obuf_claim = {1'b0, obuf_cnt} + {2'b00, pend_q} - {2'b00, pop};
        rd_issue   = (ram_occ_q != '0) && (obuf_claim < 3'(OBUF_DEPTH));

        wr_ptr_d  = push     ? wr_ptr_q + addr_t'(1) : wr_ptr_q;
        rd_ptr_d  = rd_issue ? rd_ptr_q + addr_t'(1) : rd_ptr_q;
        pend_d    = rd_issue;
        ram_occ_d = ram_occ_q;
        case ({push, rd_issue})
            2'b10:   ram_occ_d = ram_occ_q + cnt_t'(1);
            2'b01:   ram_occ_d = ram_occ_q - cnt_t'(1);
            default: ram_occ_d = ram_occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_occ_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_occ_q <= ram_occ_d;
            pend_q    <= pend_d;
        end
    end

    fifo_obuf2 u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pend_q),
        .pop       (pop),
        .load_data (ram_rdata_1),
        .head_data (head_data),
        .obuf_cnt  (obuf_cnt)
    );

    assign s.out_valid  = (obuf_cnt != 2'd0);
    assign s.out_data   = head_data;

    assign count        = ram_occ_q + cnt_t'(pend_q) + cnt_t'(obuf_cnt);
    assign full         = !s.in_ready;
    assign empty        = (count == '0);

    assign ram_we_0     = push;
    assign ram_re_0     = 1'b0;
    assign ram_addr_0   = wr_ptr_q;
    assign ram_wdata_0  = s.in_data;
    assign ram_we_1     = 1'b0;
    assign ram_re_1     = rd_issue;
    assign ram_addr_1   = rd_ptr_q;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench: directed vector table plus scoreboarded multi-cycle sequences.
module tb_dpram_fifo_ctrl;
    import dpram_fifo_pkg::*;

    logic  clk;
    logic  rst_n;
    cnt_t  count;
    logic  full, empty;
    logic  ram_we_0, ram_re_0, ram_we_1, ram_re_1;
    addr_t ram_addr_0, ram_addr_1;
    data_t ram_wdata_0, ram_rdata_1;

    dpram_fifo_ctrl_if bus ();

    dpram_fifo_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s           (bus.slave),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .ram_we_0    (ram_we_0),
        .ram_re_0    (ram_re_0),
        .ram_addr_0  (ram_addr_0),
        .ram_wdata_0 (ram_wdata_0),
        .ram_we_1    (ram_we_1),
        .ram_re_1    (ram_re_1),
        .ram_addr_1  (ram_addr_1),
        .ram_rdata_1 (ram_rdata_1)
    );

    // Behavioural 16x8 dual-port RAM with a registered read port.
    data_t mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we_0) mem[ram_addr_0] <= ram_wdata_0;
        if (ram_re_1) ram_rdata_1 <= mem[ram_addr_1];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    typedef struct {
        logic  iv;
        data_t d;
        logic  ordy;
        logic  exp_ready;
        logic  exp_valid;
        data_t exp_data;
        int    exp_count;
        logic  exp_we0;
        logic  exp_re1;
        int    exp_addr0;
    } vec_t;

    vec_t  vecs [10];
    int    total = 0;
    int    bad   = 0;
    data_t exp_q [$];
    int    model_count = 0;
    int    wr_model = 0;
    int    rd_model = 0;
    int    pop_total = 0;
    logic  prev_stall = 1'b0;
    data_t prev_data = '0;
    data_t last_pop = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic clearModel();
        exp_q.delete();
        model_count = 0;
        wr_model    = 0;
        rd_model    = 0;
        prev_stall  = 1'b0;
    endtask

    task automatic doReset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_in_ready", bus.in_ready, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_we0", ram_we_0, 0);
        checkOutput("rst_re1", ram_re_1, 0);
        rst_n = 1'b1;
        clearModel();
        #1;
    endtask

    // One clock of scoreboarded traffic: drive, check against the model, then clock.
    task automatic applyStimulus(input logic iv, input data_t d, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        checkOutput("sb_count", count, model_count);
        checkOutput("sb_empty", empty, model_count == 0);
        checkOutput("sb_re0_we1", {ram_re_0, ram_we_1}, 0);
        if (prev_stall) begin
            checkOutput("hold_valid", bus.out_valid, 1);
            checkOutput("hold_data", bus.out_data, prev_data);
        end
        if (iv && bus.in_ready) begin
            checkOutput("push_we0", ram_we_0, 1);
            checkOutput("push_addr0", ram_addr_0, wr_model);
            exp_q.push_back(d);
            wr_model    = (wr_model + 1) % DEPTH;
            model_count = model_count + 1;
        end
        if (ram_re_1) begin
            checkOutput("rd_addr1", ram_addr_1, rd_model);
            rd_model = (rd_model + 1) % DEPTH;
        end
        if (bus.out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                checkOutput("pop_underflow", 1, 0);
            end else begin
                checkOutput("pop_data", bus.out_data, exp_q.pop_front());
                model_count = model_count - 1;
            end
            last_pop = bus.out_data;
            pop_total++;
        end
        prev_stall = bus.out_valid && !ordy;
        prev_data  = bus.out_data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pops_before;
        int guard;

        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b1, 0};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0, 0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1, 1'b0, 1'b0, 0};
        vecs[4] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1};
        vecs[5] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b1, 1'b1, 2};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2, 1'b0, 1'b1, 0};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 2, 1'b0, 1'b0, 0};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 1, 1'b0, 1'b0, 0};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 0};

        doReset();

        for (int i = 0; i < 10; i++) begin
            bus.in_valid  = vecs[i].iv;
            bus.in_data   = vecs[i].d;
            bus.out_ready = vecs[i].ordy;
            #1;
            checkOutput($sformatf("v%0d_in_ready", i), bus.in_ready, vecs[i].exp_ready);
            checkOutput($sformatf("v%0d_out_valid", i), bus.out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid)
                checkOutput($sformatf("v%0d_out_data", i), bus.out_data, vecs[i].exp_data);
            checkOutput($sformatf("v%0d_count", i), count, vecs[i].exp_count);
            checkOutput($sformatf("v%0d_empty", i), empty, vecs[i].exp_count == 0);
            checkOutput($sformatf("v%0d_we0", i), ram_we_0, vecs[i].exp_we0);
            checkOutput($sformatf("v%0d_re1", i), ram_re_1, vecs[i].exp_re1);
            if (vecs[i].exp_we0)
                checkOutput($sformatf("v%0d_addr0", i), ram_addr_0, vecs[i].exp_addr0);
            @(posedge clk);
            #1;
        end

        // Fill to 18 entries with the consumer stalled.
        doReset();
        for (int i = 0; i < 18; i++) applyStimulus(1'b1, data_t'(i), 1'b0);
        checkOutput("full_count", count, 18);
        checkOutput("full_flag", full, 1);
        checkOutput("full_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        #1;
        checkOutput("full_we0_blocked", ram_we_0, 0);
        applyStimulus(1'b1, 8'h99, 1'b0);
        checkOutput("full_count_hold", count, 18);

        // Drain: 18 back-to-back pops in order.
        pops_before = pop_total;
        for (int i = 0; i < 18; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("drain_pops", pop_total - pops_before, 18);
        checkOutput("drain_empty", empty, 1);
        checkOutput("drain_last", last_pop, 8'd17);

        // Streaming: one transfer per cycle after the 3-cycle fill, pointers wrapping.
        pops_before = pop_total;
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, data_t'(100 + i), 1'b1);
        checkOutput("stream_pops", pop_total - pops_before, 37);
        guard = 0;
        while (model_count != 0 && guard < 20) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            guard++;
        end
        checkOutput("stream_drained", empty, 1);

        // Random consumer stalls and producer gaps.
        for (int i = 0; i < 120; i++)
            applyStimulus(1'($urandom_range(0, 1)), data_t'($urandom), 1'($urandom_range(0, 2) != 0));
        guard = 0;
        while (model_count != 0 && guard < 40) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            guard++;
        end
        checkOutput("rand_drained", exp_q.size(), 0);
        checkOutput("rand_empty", empty, 1);

        // Asynchronous reset mid-stream with 10 entries held.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, data_t'(8'h50 + i), 1'b0);
        checkOutput("pre_rst_count", count, 10);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", bus.out_valid, 0);
        checkOutput("async_in_ready", bus.in_ready, 1);
        checkOutput("async_full", full, 0);
        checkOutput("async_empty", empty, 1);
        checkOutput("async_count", count, 0);
        checkOutput("async_re1", ram_re_1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clearModel();
        applyStimulus(1'b1, 8'h3C, 1'b0);
        pops_before = pop_total;
        guard = 0;
        while (pop_total == pops_before && guard < 10) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            guard++;
        end
        checkOutput("post_rst_popped", pop_total - pops_before, 1);
        checkOutput("post_rst_first", last_pop, 8'h3C);
        checkOutput("post_rst_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
